cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit; successor to the fixed 4-bit CLA.

---
 rtl/cla_pipe_adder_pkg.sv | 23 ++
 rtl/cla_group.sv | 33 +++
 rtl/cla_pipe_adder.sv | 140 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // Width of one carry-lookahead group.
    localparam int unsigned GRP_W = 4;

    // Per-stage control token: travels alongside the data through the pipe.
    typedef struct packed {
        logic valid;   // stage holds a live token
        logic carry;   // carry out of all slices resolved so far
        logic a_msb;   // sign bit of operand A
        logic b_msb;   // sign bit of effective operand B'
    } stage_ctl_t;

    // Pipeline depth for a given operand width and groups-per-stage.
    function automatic int unsigned nstg(input int unsigned width, input int unsigned gps);
        if (gps == 0) begin
            return 0;
        end
        return width / (GRP_W * gps);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational 4-bit carry-lookahead group: per-bit generate/propagate,
// all internal carries derived directly from c_i (no ripple inside the group).
module cla_group
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a_i,
    input  logic [GRP_W-1:0] b_i,
    input  logic             c_i,
    output logic [GRP_W-1:0] sum_o,
    output logic             c_o
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic             c1;
    logic             c2;
    logic             c3;
    logic             c4;

    // Lookahead carries and sum bits.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c1 = g[0] | (p[0] & c_i);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c_i);
        sum_o = p ^ {c3, c2, c1, c_i};
        c_o   = c4;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready flow control.
// Stage k resolves GPS 4-bit groups of the operand; the inter-stage carry,
// the not-yet-consumed operand bits and the already-computed sum bits all
// travel together with the token so a whole result emerges on one cycle.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GPS   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int unsigned NSTG = nstg(WIDTH, GPS);
    localparam int unsigned SW   = GRP_W * GPS;

    if ((GPS == 0) || (WIDTH == 0) || ((WIDTH % (GRP_W * GPS)) != 0)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH (%0d) must be a non-zero multiple of 4*GPS (GPS=%0d)",
               WIDTH, GPS);
    end

    logic [WIDTH-1:0]           b_prep;
    logic                       cin_prep;

    // Skew registers: operand bits waiting for their stage.
    logic [WIDTH-1:0]           a_q [NSTG];
    logic [WIDTH-1:0]           b_q [NSTG];
    // Deskew registers: sum bits already resolved by earlier stages.
    logic [NSTG-1:0][WIDTH-1:0] s_q;
    stage_ctl_t [NSTG-1:0]      ctl_q;

    logic [NSTG-1:0][WIDTH-1:0] a_in;
    logic [NSTG-1:0][WIDTH-1:0] b_in;
    logic [NSTG-1:0][WIDTH-1:0] s_nxt;
    stage_ctl_t [NSTG-1:0]      ctl_in;
    logic [NSTG-1:0][SW-1:0]    gs;
    logic [NSTG-1:0]            scout;
    logic [NSTG-1:0]            vld;
    logic [NSTG-1:0]            en;

    // Operand preparation: subtraction is A + ~B + ~borrow.
    always_comb begin
        b_prep   = sub_i ? ~b_i : b_i;
        cin_prep = c_i ^ sub_i;
    end

    // Stage inputs: stage 0 takes the port operands, later stages take the
    // previous stage register; each stage splices its own slice into the sum.
    always_comb begin
        a_in[0]         = a_i;
        b_in[0]         = b_prep;
        ctl_in[0].valid = valid_i;
        ctl_in[0].carry = cin_prep;
        ctl_in[0].a_msb = a_i[WIDTH-1];
        ctl_in[0].b_msb = b_prep[WIDTH-1];
        s_nxt[0]        = '0;
        for (int unsigned k = 1; k < NSTG; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            ctl_in[k] = ctl_q[k-1];
            s_nxt[k]  = s_q[k-1];
        end
        for (int unsigned k = 0; k < NSTG; k++) begin
            s_nxt[k][SW*k +: SW] = gs[k];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        // Groups ripple their carries inside the stage; each group has its own
        // carry nets so no multi-bit vector feeds back into itself.
        for (genvar g = 0; g < GPS; g++) begin : g_grp
            logic ci;
            logic co;
            if (g == 0) begin : g_cin_stage
                assign ci = ctl_in[k].carry;
            end else begin : g_cin_ripple
                assign ci = g_grp[g-1].co;
            end
            cla_group u_grp (
                .a_i   (a_in[k][SW*k + GRP_W*g +: GRP_W]),
                .b_i   (b_in[k][SW*k + GRP_W*g +: GRP_W]),
                .c_i   (ci),
                .sum_o (gs[k][GRP_W*g +: GRP_W]),
                .c_o   (co)
            );
        end
        assign scout[k] = g_grp[GPS-1].co;
        assign vld[k]   = ctl_q[k].valid;
        // Bubble-collapsing advance: register k may load unless it and every
        // register downstream of it is full while the sink stalls.
        assign en[k]    = ready_i | ~(&vld[NSTG-1:k]);
    end

    // Pipeline registers; data only updates when a live token arrives so idle
    // outputs keep their last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            s_q   <= '0;
            ctl_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                if (en[k]) begin
                    ctl_q[k].valid <= ctl_in[k].valid;
                    if (ctl_in[k].valid) begin
                        a_q[k]         <= a_in[k];
                        b_q[k]         <= b_in[k];
                        s_q[k]         <= s_nxt[k];
                        ctl_q[k].carry <= scout[k];
                        ctl_q[k].a_msb <= ctl_in[k].a_msb;
                        ctl_q[k].b_msb <= ctl_in[k].b_msb;
                    end
                end
            end
        end
    end

    assign ready_o = en[0];
    assign valid_o = ctl_q[NSTG-1].valid;
    assign sum_o   = s_q[NSTG-1];
    assign c_o     = ctl_q[NSTG-1].carry;
    assign ovf_o   = (ctl_q[NSTG-1].a_msb == ctl_q[NSTG-1].b_msb)
                   & (s_q[NSTG-1][WIDTH-1] != ctl_q[NSTG-1].a_msb);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized bench for cla_pipe_adder (16/1, 8/2 and 32/1).
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: WIDTH=16, GPS=1 -> 4 stages.
    logic        valid_i, ready_o, c_i, sub_i, valid_o, ready_i, c_o, ovf_o;
    logic [15:0] a_i, b_i, sum_o;

    // WIDTH=8, GPS=2 -> single stage.
    logic        v8_valid, v8_ready, v8_c, v8_sub, v8_vout, v8_rin, v8_co, v8_ovf;
    logic [7:0]  v8_a, v8_b, v8_sum;

    // WIDTH=32, GPS=1 -> 8 stages.
    logic        v32_valid, v32_ready, v32_c, v32_sub, v32_vout, v32_rin, v32_co, v32_ovf;
    logic [31:0] v32_a, v32_b, v32_sum;

    cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .sub_i(sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .c_o(c_o), .ovf_o(ovf_o)
    );

    cla_pipe_adder #(.WIDTH(8), .GPS(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8_valid), .ready_o(v8_ready),
        .a_i(v8_a), .b_i(v8_b), .c_i(v8_c), .sub_i(v8_sub),
        .valid_o(v8_vout), .ready_i(v8_rin), .sum_o(v8_sum), .c_o(v8_co), .ovf_o(v8_ovf)
    );

    cla_pipe_adder #(.WIDTH(32), .GPS(1)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(v32_valid), .ready_o(v32_ready),
        .a_i(v32_a), .b_i(v32_b), .c_i(v32_c), .sub_i(v32_sub),
        .valid_o(v32_vout), .ready_i(v32_rin), .sum_o(v32_sum), .c_o(v32_co), .ovf_o(v32_ovf)
    );

    // Back-to-back stream vectors (all adds, c_i=0), hand-computed results.
    localparam logic [15:0] BB_A [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF,
                                         16'h1234, 16'h8000, 16'hABCD, 16'h7FFF};
    localparam logic [15:0] BB_B [8] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF,
                                         16'h1111, 16'h8000, 16'h1111, 16'h7FFF};
    localparam logic [15:0] BB_S [8] = '{16'h0003, 16'h0100, 16'h1000, 16'hFFFE,
                                         16'h2345, 16'h0000, 16'hBCDE, 16'hFFFE};
    localparam logic        BB_C [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // One transaction on the idle 16-bit pipe: checks acceptance, latency and result.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub, input logic [15:0] exp_sum,
                         input logic exp_c, input logic exp_ovf);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; a_i = a; b_i = b; c_i = c; sub_i = sub; ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b want 1", name, ready_o);
        end
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) valid_i = 1'b0;
            if (valid_o === 1'b1) lat = i;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 4 (0 = timeout)", name, lat);
        end
        checks++;
        if ({sum_o, c_o, ovf_o} !== {exp_sum, exp_c, exp_ovf}) begin
            errors++;
            $display("FAIL %s_result: got sum=%h c=%b ovf=%b want sum=%h c=%b ovf=%b",
                     name, sum_o, c_o, ovf_o, exp_sum, exp_c, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0; c_i = 1'b0; sub_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        checks++;
        if (sum_o !== 16'h0000) begin errors++; $display("FAIL reset_sum_o: got %h want 0000", sum_o); end
        checks++;
        if (c_o !== 1'b0) begin errors++; $display("FAIL reset_c_o: got %b want 0", c_o); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf_o: got %b want 0", ovf_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, ready_o, sum_o} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL post_reset_idle: got valid=%b ready=%b sum=%h want 0 1 0000",
                     valid_o, ready_o, sum_o);
        end
    endtask

    task automatic test_add();
        do_op("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        do_op("add_8000x2",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_sub();
        do_op("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_0_1",     16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        do_op("sub_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        do_op("sub_7fff_m1", 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int in_idx;
        int out_idx;
        in_idx = 0;
        out_idx = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 40 && out_idx < 8; t++) begin
            ready_i = !(t >= 5 && t <= 8);
            valid_i = (in_idx < 8);
            if (in_idx < 8) begin
                a_i = BB_A[in_idx]; b_i = BB_B[in_idx]; c_i = 1'b0; sub_i = 1'b0;
            end
            @(negedge clk);
            if (t == 5) begin
                checks++;
                if (ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full_ready_o: got %b want 0", ready_o);
                end
            end
            if (valid_o === 1'b1) begin
                checks++;
                if (out_idx >= 8) begin
                    errors++;
                    $display("FAIL b2b_extra_result: got sum=%h want no result", sum_o);
                end else if ({sum_o, c_o} !== {BB_S[out_idx], BB_C[out_idx]}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got sum=%h c=%b want sum=%h c=%b",
                             out_idx, sum_o, c_o, BB_S[out_idx], BB_C[out_idx]);
                end
                if (ready_i) out_idx++;
            end
            if (valid_i && ready_o === 1'b1) in_idx++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (out_idx != 8 || in_idx != 8) begin
            errors++;
            $display("FAIL b2b_count: got in=%0d out=%0d want 8 8", in_idx, out_idx);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got valid_o=%b want 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        logic leaked;
        leaked = 1'b0;
        @(posedge clk); #1;
        ready_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            valid_i = 1'b1; a_i = 16'h1000 + 16'(t); b_i = 16'h0001; c_i = 1'b0; sub_i = 1'b0;
            if (t == 2) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        valid_i = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin errors++; $display("FAIL midreset_leak: got valid_o seen=%b want 0", leaked); end
        do_op("after_midreset", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    endtask

    task automatic test_random_w8();
        logic [9:0] q[$];
        logic [9:0] e;
        logic [7:0] bp;
        logic [8:0] full;
        int n_acc;
        int n_out;
        n_acc = 0;
        n_out = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 6000 && n_out < 1000; t++) begin
            v8_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            v8_a = 8'($urandom); v8_b = 8'($urandom);
            v8_c = 1'($urandom_range(0, 1)); v8_sub = 1'($urandom_range(0, 1));
            v8_rin = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (v8_valid && v8_ready === 1'b1) begin
                bp = v8_sub ? ~v8_b : v8_b;
                full = {1'b0, v8_a} + {1'b0, bp} + 9'(v8_c ^ v8_sub);
                q.push_back({full[7:0], full[8], (v8_a[7] == bp[7]) && (full[7] != v8_a[7])});
                n_acc++;
            end
            if (v8_vout === 1'b1 && v8_rin) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL w8_unexpected: got sum=%h want no result", v8_sum);
                end else begin
                    e = q.pop_front();
                    if ({v8_sum, v8_co, v8_ovf} !== e) begin
                        errors++;
                        $display("FAIL w8_result%0d: got sum=%h c=%b ovf=%b want sum=%h c=%b ovf=%b",
                                 n_out, v8_sum, v8_co, v8_ovf, e[9:2], e[1], e[0]);
                    end
                end
                n_out++;
            end
            @(posedge clk); #1;
        end
        v8_valid = 1'b0;
        checks++;
        if (n_out != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL w8_count: got out=%0d pending=%0d want 1000 0", n_out, q.size());
        end
    endtask

    task automatic test_random_w32();
        logic [33:0] q[$];
        logic [33:0] e;
        logic [31:0] bp;
        logic [32:0] full;
        int n_acc;
        int n_out;
        n_acc = 0;
        n_out = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 6000 && n_out < 1000; t++) begin
            v32_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            v32_a = $urandom; v32_b = $urandom;
            v32_c = 1'($urandom_range(0, 1)); v32_sub = 1'($urandom_range(0, 1));
            v32_rin = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (v32_valid && v32_ready === 1'b1) begin
                bp = v32_sub ? ~v32_b : v32_b;
                full = {1'b0, v32_a} + {1'b0, bp} + 33'(v32_c ^ v32_sub);
                q.push_back({full[31:0], full[32], (v32_a[31] == bp[31]) && (full[31] != v32_a[31])});
                n_acc++;
            end
            if (v32_vout === 1'b1 && v32_rin) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL w32_unexpected: got sum=%h want no result", v32_sum);
                end else begin
                    e = q.pop_front();
                    if ({v32_sum, v32_co, v32_ovf} !== e) begin
                        errors++;
                        $display("FAIL w32_result%0d: got sum=%h c=%b ovf=%b want sum=%h c=%b ovf=%b",
                                 n_out, v32_sum, v32_co, v32_ovf, e[33:2], e[1], e[0]);
                    end
                end
                n_out++;
            end
            @(posedge clk); #1;
        end
        v32_valid = 1'b0;
        checks++;
        if (n_out != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL w32_count: got out=%0d pending=%0d want 1000 0", n_out, q.size());
        end
    endtask

    initial begin
        v8_valid = 1'b0; v8_a = '0; v8_b = '0; v8_c = 1'b0; v8_sub = 1'b0; v8_rin = 1'b1;
        v32_valid = 1'b0; v32_a = '0; v32_b = '0; v32_c = 1'b0; v32_sub = 1'b0; v32_rin = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_random_w8();
        test_random_w32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
